// File: rtl/dmem_lsu_if.sv
// Request/response bus between the MEM stage (master) and the data memory LSU (slave).
interface dmem_lsu_if #(
    parameter int ADDR_BITS = 10
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [2:0]           req_funct3;
    logic [ADDR_BITS+1:0] req_addr;
    logic [31:0]          req_wdata;
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_lsu.sv
// Data memory with load/store formatting, one outstanding access, configurable load latency.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module dmem_lsu #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 1
) (
    input  logic       clock,
    input  logic       reset,
    dmem_lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        rsp_valid_q;
    logic        rsp_fault_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] pend_rdata_q;

    logic [31:0] mem_q [0:(1<<ADDR_BITS)-1];

    logic                 accept;
    logic                 is_half;
    logic                 is_word;
    logic                 illegal;
    logic                 fault;
    logic [1:0]           off;
    logic [ADDR_BITS-1:0] word_idx;
    logic [31:0]          rd_word;
    logic [31:0]          load_fmt;
    logic [3:0]           be;
    logic [31:0]          wdata_rep;
    logic                 wr_en;

    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] o,
                                             input logic [2:0] f3);
        logic [31:0] sh;
        sh = w >> {o, 3'b000};
        case (f3)
            3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
            3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
            3'b010:  fmt_load = w;
            3'b100:  fmt_load = {24'b0, sh[7:0]};
            3'b101:  fmt_load = {16'b0, sh[15:0]};
            default: fmt_load = 32'b0;
        endcase
    endfunction

    assign accept   = bus.req_valid && (state_q == IDLE);
    assign is_half  = (bus.req_funct3[1:0] == 2'b01);
    assign is_word  = (bus.req_funct3[1:0] == 2'b10);
    assign word_idx = bus.req_addr[ADDR_BITS+1:2];

    always_comb begin
        illegal = 1'b0;
        if (bus.req_we)
            illegal = (bus.req_funct3 > 3'b010);
        else
            illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                      (bus.req_funct3 == 3'b111);
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (is_half && bus.req_addr[0]) || (is_word && (bus.req_addr[1:0] != 2'b00));
    assign fault    = illegal || misalign;
    assign off      = bus.req_addr[1:0];
`else
    assign fault    = illegal;
    // Misaligned halfword/word accesses silently drop the offending low bits.
    assign off      = is_word ? 2'b00 : (is_half ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0]);
`endif

    assign rd_word  = mem_q[word_idx];
    assign load_fmt = fmt_load(rd_word, off, bus.req_funct3);

    always_comb begin
        be        = 4'b1111;
        wdata_rep = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = bus.req_wdata;
            end
        endcase
    end

    assign wr_en = accept && bus.req_we && !fault && !reset;

    // Array has no reset so contents survive a control reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            rsp_valid_q  <= 1'b0;
            rsp_fault_q  <= 1'b0;
            rsp_rdata_q  <= 32'b0;
            pend_rdata_q <= 32'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (bus.req_we || fault || (LATENCY == 1)) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= fault;
                            rsp_rdata_q <= (bus.req_we || fault) ? 32'b0 : load_fmt;
                        end else begin
                            state_q      <= BUSY;
                            cnt_q        <= 3'(LATENCY - 1);
                            pend_rdata_q <= load_fmt;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 3'd1) begin
                        state_q     <= RESP;
                        cnt_q       <= 3'd0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pend_rdata_q;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_fault_q <= 1'b0;
                    rsp_rdata_q <= 32'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_fault = rsp_fault_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one instance at LATENCY=1, one at LATENCY=3 sharing clock/reset.
module tb_dmem_lsu;
    logic clock;
    logic reset;

    logic        t_valid;
    logic        t_we;
    logic [2:0]  t_f3;
    logic [11:0] t_addr;
    logic [31:0] t_wdata;
    logic        sel3;

    int total;
    int bad;

    dmem_lsu_if #(.ADDR_BITS(10)) if1 ();
    dmem_lsu_if #(.ADDR_BITS(10)) if3 ();

    dmem_lsu #(.ADDR_BITS(10), .LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(if1.slave));
    dmem_lsu #(.ADDR_BITS(10), .LATENCY(3)) dut3 (.clock(clock), .reset(reset), .bus(if3.slave));

    assign if1.req_valid  = t_valid & ~sel3;
    assign if3.req_valid  = t_valid & sel3;
    assign if1.req_we     = t_we;
    assign if3.req_we     = t_we;
    assign if1.req_funct3 = t_f3;
    assign if3.req_funct3 = t_f3;
    assign if1.req_addr   = t_addr;
    assign if3.req_addr   = t_addr;
    assign if1.req_wdata  = t_wdata;
    assign if3.req_wdata  = t_wdata;

    logic        ready_s;
    logic        valid_s;
    logic [31:0] rdata_s;
    logic        fault_s;
    assign ready_s = sel3 ? if3.req_ready : if1.req_ready;
    assign valid_s = sel3 ? if3.rsp_valid : if1.rsp_valid;
    assign rdata_s = sel3 ? if3.rsp_rdata : if1.rsp_rdata;
    assign fault_s = sel3 ? if3.rsp_fault : if1.rsp_fault;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one request on the selected instance, returns the response and edges-to-response.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [11:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                        output int lat);
        int n;
        n = 0;
        while (!ready_s && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!ready_s) chk("ready_wait", 32'(ready_s), 32'd1);
        t_we    = we;
        t_f3    = f3;
        t_addr  = a;
        t_wdata = wd;
        t_valid = 1'b1;
        @(posedge clock);
        #1 t_valid = 1'b0;
        lat = 99;
        rd  = 32'hx;
        flt = 1'bx;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (valid_s) begin
                lat = i;
                rd  = rdata_s;
                flt = fault_s;
                break;
            end
        end
        @(negedge clock);
        chk("one_shot", 32'(valid_s), 32'd0);
        chk("idle_rdata", rdata_s, 32'd0);
    endtask

    logic [31:0] rd;
    logic        flt;
    int          lat;
    logic [6:0]  exp_rdy_v;
    logic [6:0]  exp_vld_v;
    logic [31:0] exp_rd;
    int          seen;

    initial begin
        total   = 0;
        bad     = 0;
        sel3    = 1'b0;
        t_valid = 1'b0;
        t_we    = 1'b0;
        t_f3    = 3'b0;
        t_addr  = 12'h0;
        t_wdata = 32'h0;
        reset   = 1'b1;
        #3;
        chk("rst_ready", 32'(if1.req_ready), 32'd1);
        chk("rst_valid", 32'(if1.rsp_valid), 32'd0);
        chk("rst_rdata", if1.rsp_rdata, 32'd0);
        chk("rst_fault", 32'(if1.rsp_fault), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // LATENCY=1 instance
        xact(1'b1, 3'b010, 12'h010, 32'hDEADBEEF, rd, flt, lat);
        chk("sw_lat", 32'(lat), 32'd1);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_fault", 32'(flt), 32'd0);
        xact(1'b0, 3'b010, 12'h010, 32'h0, rd, flt, lat);
        chk("lw_lat", 32'(lat), 32'd1);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_fault", 32'(flt), 32'd0);
        xact(1'b0, 3'b000, 12'h013, 32'h0, rd, flt, lat);
        chk("lb_13", rd, 32'hFFFFFFDE);
        xact(1'b0, 3'b100, 12'h013, 32'h0, rd, flt, lat);
        chk("lbu_13", rd, 32'h000000DE);
        xact(1'b0, 3'b001, 12'h012, 32'h0, rd, flt, lat);
        chk("lh_12", rd, 32'hFFFFDEAD);
        xact(1'b0, 3'b101, 12'h010, 32'h0, rd, flt, lat);
        chk("lhu_10", rd, 32'h0000BEEF);
        xact(1'b1, 3'b000, 12'h011, 32'hAAAAAA55, rd, flt, lat);
        xact(1'b0, 3'b010, 12'h010, 32'h0, rd, flt, lat);
        chk("sb_merge", rd, 32'hDEAD55EF);
        xact(1'b1, 3'b001, 12'h012, 32'hBBBB1234, rd, flt, lat);
        xact(1'b0, 3'b010, 12'h010, 32'h0, rd, flt, lat);
        chk("sh_merge", rd, 32'h123455EF);

        xact(1'b0, 3'b011, 12'h010, 32'h0, rd, flt, lat);
        chk("ill_ld_fault", 32'(flt), 32'd1);
        chk("ill_ld_rdata", rd, 32'd0);
        chk("ill_ld_lat", 32'(lat), 32'd1);
        xact(1'b1, 3'b100, 12'h010, 32'hFFFFFFFF, rd, flt, lat);
        chk("ill_st_fault", 32'(flt), 32'd1);
        chk("ill_st_rdata", rd, 32'd0);
        xact(1'b0, 3'b010, 12'h010, 32'h0, rd, flt, lat);
        chk("ill_st_nowrite", rd, 32'h123455EF);

        xact(1'b0, 3'b010, 12'h012, 32'h0, rd, flt, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_lw_fault", 32'(flt), 32'd1);
        chk("mis_lw_rdata", rd, 32'd0);
`else
        chk("mis_lw_fault", 32'(flt), 32'd0);
        chk("mis_lw_rdata", rd, 32'h123455EF);
`endif

        // LATENCY=3 instance
        sel3 = 1'b1;
        @(negedge clock);
        xact(1'b1, 3'b010, 12'h020, 32'hCAFEF00D, rd, flt, lat);
        chk("l3_sw_lat", 32'(lat), 32'd1);

        // Back-to-back: LW then LHU held on req_valid until ready returns
        t_we    = 1'b0;
        t_f3    = 3'b010;
        t_addr  = 12'h020;
        t_valid = 1'b1;
        @(posedge clock);
        #1 t_f3 = 3'b101;
        exp_rdy_v = 7'b0001000;
        exp_vld_v = 7'b1000100;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clock);
            exp_rd = (n == 3) ? 32'hCAFEF00D : ((n == 7) ? 32'h0000F00D : 32'h0);
            chk($sformatf("l3_ready_%0d", n), 32'(ready_s), 32'(exp_rdy_v[n-1]));
            chk($sformatf("l3_valid_%0d", n), 32'(valid_s), 32'(exp_vld_v[n-1]));
            chk($sformatf("l3_rdata_%0d", n), rdata_s, exp_rd);
            if (n == 5) t_valid = 1'b0;
        end
        @(negedge clock);

        // Reset while BUSY drops the pending response
        t_f3    = 3'b010;
        t_valid = 1'b1;
        @(posedge clock);
        #1 t_valid = 1'b0;
        @(negedge clock);
        chk("busy_ready", 32'(ready_s), 32'd0);
        reset = 1'b1;
        #2;
        chk("rst_mid_ready", 32'(ready_s), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (valid_s) seen++;
        end
        chk("rst_no_rsp", 32'(seen), 32'd0);
        chk("rst_after_ready", 32'(ready_s), 32'd1);
        xact(1'b0, 3'b010, 12'h020, 32'h0, rd, flt, lat);
        chk("l3_lw_lat", 32'(lat), 32'd3);
        chk("l3_lw_kept", rd, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Parametrised data memory with an integrated load/store formatter for the RISC-V core's MEM stage. It replaces a bare byte-enabled word array with a request/response interface that has configurable read latency. It also takes over byte-lane steering, sign/zero extension, illegal-op detection and misalignment handling from the datapath. One transaction is outstanding at a time.

Parameters:
- ADDR_BITS, 10, number of word-address bits; the array holds 2**ADDR_BITS 32-bit words.
- LATENCY, 1, load latency in clock edges, legal range 1..4. Stores always take 1 edge.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears control state only.
- req_valid, input, 1, request present.
- req_ready, output, 1, block can accept a request.
- req_we, input, 1, 1 = store, 0 = load.
- req_funct3, input, 3, RISC-V funct3 of the load/store.
- req_addr, input, ADDR_BITS+2, byte address.
- req_wdata, input, 32, store data, right-aligned in the low bits.
- rsp_valid, output, 1, one-cycle response strobe.
- rsp_rdata, output, 32, formatted load data.
- rsp_fault, output, 1, access rejected.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0. The FSM resets to IDLE and the latency counter to 0.
- Memory contents are not cleared by reset. No write occurs while reset is high.
- Accept: a request is accepted on a rising edge where req_valid && req_ready.
- req_ready = (state==IDLE). Requests are not queued.
- FSM states and transitions:
  - IDLE: on accept with (store or fault) or LATENCY==1, go to RESP. On accept of a good load with LATENCY>1, go to BUSY with cnt=LATENCY-1.
  - BUSY: decrement cnt; when cnt reaches 1, go to RESP on the next edge.
  - RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
- Load timing: rsp_valid is high in the cycle following the LATENCY-th edge, counting the accepting edge as edge 1. With LATENCY=1, the response appears in the cycle right after accept.
- Throughput is one access per LATENCY+1 cycles.
- Store timing: the write is committed at the accepting edge; the response comes one edge later. Stores use byte enables:
  - SB: lane addr[1:0].
  - SH: lanes {addr[1],0} and {addr[1],1}.
  - SW: all four lanes.
  - Write data is replicated to the selected lanes from req_wdata[7:0] / [15:0] / [31:0].
- Load read: the whole word is captured at the accepting edge. Lane select and extension then apply:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Illegal funct3 (loads 011/110/111; stores other than 000/001/010): rsp_fault=1, no write, rsp_rdata=0, response after 1 edge.
- rsp_rdata and rsp_fault are 0 whenever rsp_valid=0. rsp_rdata is 0 for all stores.
- req_* inputs are ignored outside the accepting edge.
- Reset mid-operation: the FSM returns to IDLE immediately and the pending response is dropped, never emitted. A store already committed before reset stays written.
- Address wrap: the word index is req_addr[ADDR_BITS+1:2]. There are no upper address bits, so no out-of-range condition exists.

Optional Feature:
- DMEM_MISALIGN_TRAP_EN defined: these accesses complete with rsp_fault=1, no write and rsp_rdata=0, after 1 edge:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
- DMEM_MISALIGN_TRAP_EN undefined: the offending low address bits are forced to 0 (halfword: addr[0]; word: addr[1:0]). The access proceeds normally and rsp_fault is never set for misalignment.

Test Plan:
- LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10. The store response comes 1 cycle after accept; the load returns rsp_rdata=0xDEADBEEF 1 cycle after accept; rsp_fault=0.
- After the above, LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- SB 0x55 @0x11 over 0xDEADBEEF, then LW @0x10 → 0xDEAD55EF. SH 0x1234 @0x12, then LW → 0x123455EF.
- LATENCY=3: LW accepted at edge 0 → rsp_valid high only in the cycle after edge 2; req_ready=0 from accept until rsp_valid falls. A second req_valid held high is accepted on the first edge where req_ready=1.
- Load with funct3=011, and a store with funct3=100 → rsp_fault=1, rsp_rdata=0, memory word unchanged.
- LW @0x12: with DMEM_MISALIGN_TRAP_EN → fault=1, rdata=0; without → returns the word @0x10. Separately, assert reset in BUSY (LATENCY=3) → no rsp_valid is emitted and req_ready=1 after reset.
